// File: rtl/pipelined_mult_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake, sideband tag and flush.
// Optional occupancy counter port enabled by defining PMULT_OCCUPANCY_EN.
module pipelined_mult_hs #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int STAGES    = 3,
    parameter int TAG_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [A_WIDTH-1:0]           a,
    input  logic [B_WIDTH-1:0]           b,
    input  logic [TAG_WIDTH-1:0]         tag_in,
    input  logic                         signed_mode,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0]   product,
    output logic [TAG_WIDTH-1:0]         tag_out
`ifdef PMULT_OCCUPANCY_EN
    ,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
`endif
);

    localparam int P = A_WIDTH + B_WIDTH;

    function automatic logic [P-1:0] ext_a(input logic [A_WIDTH-1:0] v, input logic s);
        ext_a = s ? {{B_WIDTH{v[A_WIDTH-1]}}, v} : {{B_WIDTH{1'b0}}, v};
    endfunction

    function automatic logic [P-1:0] ext_b(input logic [B_WIDTH-1:0] v, input logic s);
        ext_b = s ? {{A_WIDTH{v[B_WIDTH-1]}}, v} : {{A_WIDTH{1'b0}}, v};
    endfunction

    // Product of two P-bit extended operands is exact modulo 2^P for both signednesses.
    function automatic logic [P-1:0] mul_p(input logic [P-1:0] x, input logic [P-1:0] y);
        mul_p = x * y;
    endfunction

    logic w_adv;
    logic w_in_xfer;

    // in_ready is gated by reset so nothing is offered while the block is held in reset.
    assign w_adv     = (!out_valid || out_ready) && !flush;
    assign in_ready  = w_adv && reset_n;
    assign w_in_xfer = in_valid && in_ready;

    if (STAGES == 1) begin : g_single
        // Single stage: multiply at the input and register the result once.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_valid <= 1'b0;
                product   <= '0;
                tag_out   <= '0;
            end else if (flush) begin
                out_valid <= 1'b0;
            end else if (w_adv) begin
                out_valid <= w_in_xfer;
                product   <= mul_p(ext_a(a, signed_mode), ext_b(b, signed_mode));
                tag_out   <= tag_in;
            end
        end
    end else begin : g_multi
        logic                 r_v0;
        logic                 r_s0;
        logic [A_WIDTH-1:0]   r_a0;
        logic [B_WIDTH-1:0]   r_b0;
        logic [TAG_WIDTH-1:0] r_t0;
        logic [P-1:0]         w_mul;
        logic [STAGES-1:1]    r_v;
        logic [P-1:0]         r_p [1:STAGES-1];
        logic [TAG_WIDTH-1:0] r_t [1:STAGES-1];

        // Stage 0 captures raw operands with their signedness.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_v0 <= 1'b0;
                r_s0 <= 1'b0;
                r_a0 <= '0;
                r_b0 <= '0;
                r_t0 <= '0;
            end else if (flush) begin
                r_v0 <= 1'b0;
            end else if (w_adv) begin
                r_v0 <= w_in_xfer;
                r_s0 <= signed_mode;
                r_a0 <= a;
                r_b0 <= b;
                r_t0 <= tag_in;
            end
        end

        assign w_mul = mul_p(ext_a(r_a0, r_s0), ext_b(r_b0, r_s0));

        // Stage 1 takes the product; later stages shift it toward the output.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_v <= '0;
                for (int k = 1; k < STAGES; k++) begin
                    r_p[k] <= '0;
                    r_t[k] <= '0;
                end
            end else if (flush) begin
                r_v <= '0;
            end else if (w_adv) begin
                r_v[1] <= r_v0;
                r_p[1] <= w_mul;
                r_t[1] <= r_t0;
                for (int k = 2; k < STAGES; k++) begin
                    r_v[k] <= r_v[k-1];
                    r_p[k] <= r_p[k-1];
                    r_t[k] <= r_t[k-1];
                end
            end
        end

        assign out_valid = r_v[STAGES-1];
        assign product   = r_p[STAGES-1];
        assign tag_out   = r_t[STAGES-1];
    end

`ifdef PMULT_OCCUPANCY_EN
    localparam int OW = $clog2(STAGES + 1);
    logic [OW-1:0] r_occ;
    logic          w_out_xfer;

    assign w_out_xfer = out_valid && out_ready;

    // Occupancy mirrors the number of valid stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OW'(1'b1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OW'(1'b1);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule
